except_ctrl: RTL and testbench

Pipeline exception and stall controller for the five-stage core. Each cycle it arbitrates the ID/EX stall requests against exceptions reported by the MEM stage and pending interrupts from CP0. It sequences exception entry and ERET return: it produces the `excepttype` code, faulting PC and delay-slot flag consumed by cp0_reg, and drives the pipeline `stall`, `flush` and `new_pc` controls. It sits between the MEM stage, cp0_reg and the PC/pipeline registers.

---
 rtl/except_ctrl_pkg.sv | 40 ++++
 rtl/except_ctrl_if.sv | 44 ++++
 rtl/except_ctrl_prio_enc.sv | 34 +++
 rtl/except_ctrl.sv | 109 ++++++++++
 tb/tb_except_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception/stall controller: exception codes,
// CP0 register addresses, stall vectors and the FSM state type.
package except_ctrl_pkg;

  localparam int          RegBus    = 32;
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Exception codes reported to cp0_reg
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // Bit positions of the raw MEM-stage exception flags
  localparam int FLAG_SYSCALL = 8;
  localparam int FLAG_INVALID = 9;
  localparam int FLAG_OV      = 10;
  localparam int FLAG_TRAP    = 11;
  localparam int FLAG_ERET    = 12;

  // CP0 register addresses seen on the WB mtc0 path
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Stall vectors, bit0 = PC ... bit5 = WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FLUSH  = 1'b1
  } state_e;

endpackage

// File: rtl/except_ctrl_if.sv
// Bundle of MEM-stage, CP0 and pipeline-control signals around except_ctrl.
// slave = the controller, master = the surrounding pipeline / testbench.
interface except_ctrl_if;
  import except_ctrl_pkg::*;

  logic              stallreq_from_id_i;
  logic              stallreq_from_ex_i;
  logic              mem_inst_valid_i;
  logic [RegBus-1:0] mem_except_i;
  logic [RegBus-1:0] mem_inst_addr_i;
  logic              mem_is_in_delayslot_i;
  logic [RegBus-1:0] cp0_status_i;
  logic [RegBus-1:0] cp0_cause_i;
  logic [RegBus-1:0] cp0_epc_i;
  logic              wb_cp0_we_i;
  logic [4:0]        wb_cp0_waddr_i;
  logic [RegBus-1:0] wb_cp0_data_i;

  logic [RegBus-1:0] excepttype_o;
  logic [RegBus-1:0] current_inst_addr_o;
  logic              is_in_delayslot_o;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic [RegBus-1:0] new_pc_o;

  modport slave (
    input  stallreq_from_id_i, stallreq_from_ex_i, mem_inst_valid_i,
           mem_except_i, mem_inst_addr_i, mem_is_in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           stall_o, flush_o, new_pc_o
  );

  modport master (
    output stallreq_from_id_i, stallreq_from_ex_i, mem_inst_valid_i,
           mem_except_i, mem_inst_addr_i, mem_is_in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           stall_o, flush_o, new_pc_o
  );

endinterface

// File: rtl/except_ctrl_prio_enc.sv
// Priority encoder: effective status/cause plus raw MEM flags -> exception code.
// Order: interrupt, syscall, invalid, trap, overflow, eret.
module except_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic [RegBus-1:0] status_i,
  input  logic [RegBus-1:0] cause_i,
  input  logic [RegBus-1:0] except_i,
  output logic [RegBus-1:0] excepttype_o
);

  logic int_pending;

  // Interrupt taken only with IE set, EXL clear and an enabled pending line
  assign int_pending = status_i[0] & ~status_i[1] &
                       (|(cause_i[15:8] & status_i[15:8]));

  // Bits that play no part in the decision
  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16],
                         cause_i[7:0], except_i[31:13], except_i[7:0]};

  // Fixed-priority selection of the exception code
  always_comb begin
    excepttype_o = EXC_NONE;
    if (int_pending)                 excepttype_o = EXC_INT;
    else if (except_i[FLAG_SYSCALL]) excepttype_o = EXC_SYSCALL;
    else if (except_i[FLAG_INVALID]) excepttype_o = EXC_INVALID;
    else if (except_i[FLAG_TRAP])    excepttype_o = EXC_TRAP;
    else if (except_i[FLAG_OV])      excepttype_o = EXC_OV;
    else if (except_i[FLAG_ERET])    excepttype_o = EXC_ERET;
  end

endmodule

// File: rtl/except_ctrl.sv
// Exception and stall controller: arbitrates stall requests against MEM-stage
// exceptions and interrupts, sequences the flush window and redirect PC.
// Detection outputs are combinational in the detection cycle; the FSM holds
// flush_o and the latched redirect for the remaining flush cycles.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  except_ctrl_if.slave  bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RegBus-1:0] pc_q, pc_d;

  logic [RegBus-1:0] eff_status;
  logic [RegBus-1:0] eff_cause;
  logic [RegBus-1:0] eff_epc;
  logic [RegBus-1:0] code_raw;
  logic [RegBus-1:0] excepttype;
  logic              flush;
  logic [RegBus-1:0] new_pc;

  // Bypass an mtc0 still in WB so this cycle sees the value being written
  always_comb begin
    eff_status = bus.cp0_status_i;
    eff_cause  = bus.cp0_cause_i;
    eff_epc    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == CP0_REG_STATUS) eff_status = bus.wb_cp0_data_i;
      // only the software-interrupt bits of cause are writable
      if (bus.wb_cp0_waddr_i == CP0_REG_CAUSE)  eff_cause[9:8] = bus.wb_cp0_data_i[9:8];
      if (bus.wb_cp0_waddr_i == CP0_REG_EPC)    eff_epc = bus.wb_cp0_data_i;
    end
  end

  except_prio_enc u_prio_enc (
    .status_i     (eff_status),
    .cause_i      (eff_cause),
    .except_i     (bus.mem_except_i),
    .excepttype_o (code_raw)
  );

  // Detection, redirect selection and next-state for the flush sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    excepttype = EXC_NONE;
    flush      = 1'b0;
    new_pc     = ZeroWord;
    unique case (state_q)
      ST_NORMAL: begin
        // bubbles never take an exception; a pending interrupt waits
        if (bus.mem_inst_valid_i) excepttype = code_raw;
        if (excepttype != EXC_NONE) begin
          flush  = 1'b1;
          new_pc = (excepttype == EXC_ERET) ? eff_epc : EXC_VECTOR;
          pc_d   = new_pc;
          cnt_d  = CNT_W'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES > 1) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // MEM contents are being squashed, so they are ignored here
        flush  = 1'b1;
        new_pc = pc_q;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Flush sequencer state, counter and latched redirect target
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
      pc_q    <= ZeroWord;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Stall vector; a flush always wins over a stall
  always_comb begin
    bus.stall_o = STALL_NONE;
    if (!flush) begin
      if (bus.stallreq_from_ex_i)      bus.stall_o = STALL_EX;
      else if (bus.stallreq_from_id_i) bus.stall_o = STALL_ID;
    end
  end

  assign bus.excepttype_o        = excepttype;
  assign bus.flush_o             = flush;
  assign bus.new_pc_o            = new_pc;
  assign bus.current_inst_addr_o = bus.mem_inst_addr_i;
  assign bus.is_in_delayslot_o   = bus.mem_is_in_delayslot_i;

endmodule

// File: tb/tb_except_ctrl.sv
// Testbench for except_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int          FC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  except_ctrl_if bus ();

  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model state: remaining flush cycles after the current one and held redirect
  int          m_left = 0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_code;
  logic [31:0] m_newpc;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    bus.stallreq_from_id_i    = 1'b0;
    bus.stallreq_from_ex_i    = 1'b0;
    bus.mem_inst_valid_i      = 1'b0;
    bus.mem_except_i          = 32'h0;
    bus.mem_inst_addr_i       = 32'h0;
    bus.mem_is_in_delayslot_i = 1'b0;
    bus.cp0_status_i          = 32'h0;
    bus.cp0_cause_i           = 32'h0;
    bus.cp0_epc_i             = 32'h0;
    bus.wb_cp0_we_i           = 1'b0;
    bus.wb_cp0_waddr_i        = 5'd0;
    bus.wb_cp0_data_i         = 32'h0;
  endtask

  // Compute the required outputs from the rules and compare, mid-cycle
  task automatic at_neg();
    logic [31:0] st, ca, ep, code, npc, ex;
    logic        pend, fl;
    logic [5:0]  stl;
    @(negedge clk);
    st = bus.cp0_status_i;
    ca = bus.cp0_cause_i;
    ep = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) ca[9:8] = bus.wb_cp0_data_i[9:8];
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_data_i;
    pend = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0);
    ex   = bus.mem_except_i;
    code = 32'h0;
    if (m_left == 0 && bus.mem_inst_valid_i) begin
      if (pend)       code = 32'h1;
      else if (ex[8]) code = 32'h8;
      else if (ex[9]) code = 32'ha;
      else if (ex[11]) code = 32'hd;
      else if (ex[10]) code = 32'hc;
      else if (ex[12]) code = 32'he;
    end
    fl  = (m_left > 0) || (code != 0);
    if (m_left > 0)        npc = m_pc;
    else if (code == 0)    npc = 32'h0;
    else if (code == 32'he) npc = ep;
    else                   npc = VEC;
    if (fl)                          stl = 6'h00;
    else if (bus.stallreq_from_ex_i) stl = 6'h0f;
    else if (bus.stallreq_from_id_i) stl = 6'h07;
    else                             stl = 6'h00;
    m_code  = code;
    m_newpc = npc;
    cmp("excepttype", bus.excepttype_o, code);
    cmp("flush", {31'b0, bus.flush_o}, {31'b0, fl});
    cmp("new_pc", bus.new_pc_o, npc);
    cmp("stall", {26'b0, bus.stall_o}, {26'b0, stl});
    cmp("cur_addr", bus.current_inst_addr_o, bus.mem_inst_addr_i);
    cmp("delayslot", {31'b0, bus.is_in_delayslot_o}, {31'b0, bus.mem_is_in_delayslot_i});
  endtask

  // Advance the model across the clock edge, then release inputs for driving
  task automatic next();
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_pc   = 32'h0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (m_code != 0) begin
      m_left = FC - 1;
      m_pc   = m_newpc;
    end
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (FC) begin at_neg(); next(); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;

    // reset state
    at_neg();
    cmp("lit_rst_code", bus.excepttype_o, 32'h0);
    cmp("lit_rst_flush", {31'b0, bus.flush_o}, 32'h0);
    cmp("lit_rst_newpc", bus.new_pc_o, 32'h0);
    cmp("lit_rst_stall", {26'b0, bus.stall_o}, 32'h0);
    next();

    // syscall and its flush window
    bus.mem_inst_valid_i = 1'b1;
    bus.mem_except_i     = 32'h100;
    bus.mem_inst_addr_i  = 32'h100;
    at_neg();
    cmp("lit_sys_code", bus.excepttype_o, 32'h8);
    cmp("lit_sys_flush", {31'b0, bus.flush_o}, 32'h1);
    cmp("lit_sys_newpc", bus.new_pc_o, 32'h20);
    next();
    idle();
    at_neg();
    cmp("lit_sys_t1_flush", {31'b0, bus.flush_o}, 32'h1);
    cmp("lit_sys_t1_code", bus.excepttype_o, 32'h0);
    next();
    at_neg();
    cmp("lit_sys_t2_flush", {31'b0, bus.flush_o}, 32'h0);
    next();

    // interrupt beats overflow, masked by EXL
    bus.mem_inst_valid_i = 1'b1;
    bus.cp0_status_i     = 32'h0000_0401;
    bus.cp0_cause_i      = 32'h0000_0400;
    bus.mem_except_i     = 32'h400;
    at_neg();
    cmp("lit_int_prio", bus.excepttype_o, 32'h1);
    next();
    drain();
    bus.mem_inst_valid_i = 1'b1;
    bus.cp0_status_i     = 32'h0000_0403;
    bus.cp0_cause_i      = 32'h0000_0400;
    bus.mem_except_i     = 32'h400;
    at_neg();
    cmp("lit_ov_exl", bus.excepttype_o, 32'hc);
    next();
    drain();

    // eret with EPC bypass from WB
    bus.mem_inst_valid_i = 1'b1;
    bus.mem_except_i     = 32'h1000;
    bus.cp0_epc_i        = 32'h200;
    bus.wb_cp0_we_i      = 1'b1;
    bus.wb_cp0_waddr_i   = 5'd14;
    bus.wb_cp0_data_i    = 32'h300;
    at_neg();
    cmp("lit_eret_code", bus.excepttype_o, 32'he);
    cmp("lit_eret_newpc", bus.new_pc_o, 32'h300);
    next();
    drain();

    // stall versus flush
    bus.stallreq_from_ex_i = 1'b1;
    at_neg();
    cmp("lit_stall_ex", {26'b0, bus.stall_o}, 32'h0f);
    next();
    bus.mem_inst_valid_i = 1'b1;
    bus.mem_except_i     = 32'h200;
    at_neg();
    cmp("lit_sf_stall", {26'b0, bus.stall_o}, 32'h0);
    cmp("lit_sf_flush", {31'b0, bus.flush_o}, 32'h1);
    cmp("lit_sf_code", bus.excepttype_o, 32'ha);
    next();
    drain();

    // interrupt deferred across a bubble, trap ignored during flush
    bus.cp0_status_i = 32'h0000_0401;
    bus.cp0_cause_i  = 32'h0000_0400;
    at_neg();
    cmp("lit_bubble_code", bus.excepttype_o, 32'h0);
    next();
    bus.mem_inst_valid_i = 1'b1;
    at_neg();
    cmp("lit_bubble_int", bus.excepttype_o, 32'h1);
    next();
    bus.cp0_status_i = 32'h0;
    bus.mem_except_i = 32'h800;
    at_neg();
    cmp("lit_trap_ign_code", bus.excepttype_o, 32'h0);
    cmp("lit_trap_ign_flush", {31'b0, bus.flush_o}, 32'h1);
    next();
    drain();

    // status write clearing IE suppresses an interrupt in the same cycle
    bus.mem_inst_valid_i = 1'b1;
    bus.cp0_status_i     = 32'h0000_0401;
    bus.cp0_cause_i      = 32'h0000_0400;
    bus.wb_cp0_we_i      = 1'b1;
    bus.wb_cp0_waddr_i   = 5'd12;
    bus.wb_cp0_data_i    = 32'h0000_0400;
    at_neg();
    cmp("lit_ie_bypass", bus.excepttype_o, 32'h0);
    next();
    idle();

    // reset in the middle of a flush
    bus.mem_inst_valid_i = 1'b1;
    bus.mem_except_i     = 32'h100;
    at_neg();
    next();
    idle();
    rst = 1'b1;
    at_neg();
    next();
    rst = 1'b0;
    at_neg();
    cmp("lit_rstmid_flush", {31'b0, bus.flush_o}, 32'h0);
    cmp("lit_rstmid_newpc", bus.new_pc_o, 32'h0);
    cmp("lit_rstmid_code", bus.excepttype_o, 32'h0);
    cmp("lit_rstmid_stall", {26'b0, bus.stall_o}, 32'h0);
    next();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst                       = ($urandom_range(0, 63) == 0);
      bus.stallreq_from_id_i    = $urandom_range(0, 1) == 1;
      bus.stallreq_from_ex_i    = $urandom_range(0, 3) == 0;
      bus.mem_inst_valid_i      = $urandom_range(0, 3) != 0;
      bus.mem_except_i          = ($urandom & 32'hFFFF_E0FF) |
                                  (($urandom_range(0, 2) == 0) ? ($urandom & 32'h1F00) : 32'h0);
      bus.mem_inst_addr_i       = $urandom;
      bus.mem_is_in_delayslot_i = $urandom_range(0, 1) == 1;
      bus.cp0_status_i          = $urandom & 32'hFFFF_FF03;
      bus.cp0_cause_i           = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_00FF);
      bus.cp0_epc_i             = $urandom;
      bus.wb_cp0_we_i           = $urandom_range(0, 1) == 1;
      bus.wb_cp0_waddr_i        = 5'($urandom_range(11, 14));
      bus.wb_cp0_data_i         = $urandom;
      at_neg();
      next();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
